// File: rtl/sbox_sched_pkg.sv
// Shared constants, FSM encoding and a byte-select helper for the S-box BRAM lookup scheduler.
package sbox_sched_pkg;

  localparam int BYTES     = 16;
  localparam int RD_LAT    = 2;
  localparam int SEL_W     = 2;
  localparam int ADDR_W    = SEL_W + 8;
  localparam int ISSUE_CYC = BYTES / 2;
  localparam int TAG_W     = (ISSUE_CYC > 1) ? $clog2(ISSUE_CYC) : 1;
  localparam int STATE_W   = 8 * BYTES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  function automatic logic [7:0] get_byte(input logic [STATE_W-1:0] s, input int unsigned idx);
    return s[8*idx +: 8];
  endfunction

endpackage

// File: rtl/sbox_sched_tag_pipe.sv
// Valid+tag delay line matching the BRAM read latency, so each returning byte pair knows its slot.
module sbox_sched_tag_pipe
  import sbox_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             vld_o,
  output logic [TAG_W-1:0] tag_o
);

  logic [RD_LAT-1:0]            vld_q;
  logic [RD_LAT-1:0][TAG_W-1:0] tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
    end else begin
      vld_q[0] <= push_i;
      tag_q[0] <= tag_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[RD_LAT-1];
  assign tag_o = tag_q[RD_LAT-1];

endmodule

// File: rtl/sbox_bram_lookup_sched.sv
// Runs a 128-bit masked state through a dual-port S-box BRAM, two bytes per cycle,
// and presents the substituted state on a valid/ready output.
module sbox_bram_lookup_sched
  import sbox_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [STATE_W-1:0] in_state_i,
  input  logic [SEL_W-1:0]   in_sel_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [STATE_W-1:0] out_state_o,
  output logic [ADDR_W-1:0]  bram_addra_o,
  output logic [ADDR_W-1:0]  bram_addrb_o,
  output logic               bram_en_o,
  output logic               bram_rst_o,
  input  logic [7:0]         bram_doa_i,
  input  logic [7:0]         bram_dob_i
);

  localparam logic [TAG_W-1:0] LAST_TAG = TAG_W'(ISSUE_CYC - 1);

  sched_state_e       state_q, state_d;
  logic [TAG_W-1:0]   k_q, k_d;
  logic [TAG_W-1:0]   cap_q, cap_d;
  logic [STATE_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [STATE_W-1:0] out_q, out_d;
  logic [ADDR_W-1:0]  addra_q, addra_d;
  logic [ADDR_W-1:0]  addrb_q, addrb_d;
  logic               push;
  logic               cap_vld;
  logic [TAG_W-1:0]   cap_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      cap_q   <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      addra_q <= '0;
      addrb_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      addra_q <= addra_d;
      addrb_q <= addrb_d;
    end
  end

  // Addresses are registered one cycle ahead so the pins only move on issue cycles.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cap_d   = cap_q;
    data_d  = data_q;
    sel_d   = sel_q;
    out_d   = out_q;
    addra_d = addra_q;
    addrb_d = addrb_q;
    push    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          data_d  = in_state_i;
          sel_d   = in_sel_i;
          addra_d = {in_sel_i, in_state_i[7:0]};
          addrb_d = {in_sel_i, in_state_i[15:8]};
          k_d     = '0;
          cap_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        push = 1'b1;
        if (k_q == LAST_TAG) begin
          state_d = DRAIN;
        end else begin
          k_d     = k_q + 1'b1;
          addra_d = {sel_q, get_byte(data_q, 2 * (32'(k_q) + 1))};
          addrb_d = {sel_q, get_byte(data_q, 2 * (32'(k_q) + 1) + 1)};
        end
      end
      DRAIN: ;
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The BRAM output register only advances while enabled, so capture is gated the same way.
    if (bram_en_o && cap_vld) begin
      for (int i = 0; i < ISSUE_CYC; i++) begin
        if (cap_tag == TAG_W'(i)) begin
          out_d[16*i +: 8]     = bram_doa_i;
          out_d[16*i + 8 +: 8] = bram_dob_i;
        end
      end
      cap_d = cap_q + 1'b1;
      if (state_q == DRAIN && cap_q == LAST_TAG) state_d = DONE;
    end
  end

  sbox_sched_tag_pipe u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .tag_i  (k_q),
    .vld_o  (cap_vld),
    .tag_o  (cap_tag)
  );

  assign in_ready_o   = (state_q == IDLE);
  assign out_valid_o  = (state_q == DONE);
  assign out_state_o  = out_q;
  assign bram_addra_o = addra_q;
  assign bram_addrb_o = addrb_q;
  assign bram_en_o    = (state_q == ISSUE) || (state_q == DRAIN);
  assign bram_rst_o   = ~rst_n;

endmodule
